// File: rtl/cmd_executor.sv
// Command execution engine: runs decoded UART commands against SRAM
// and hands word/byte responses to the UART transmitter.
module cmd_executor #(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int BURST_W    = 4,
  parameter bit ACK_WRITES = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  input  logic [7:0]        cmd_opcode,
  input  logic [ADDR_W-1:0] cmd_address,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [1:0]        cmd_error,
  output logic              cmd_ready,
  output logic              mem_enable,
  output logic              mem_read_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              tx_enable,
  output logic              tx_mode_select,
  output logic [DATA_W-1:0] tx_word,
  output logic [7:0]        tx_byte,
  input  logic              tx_done,
  output logic              busy,
  output logic [7:0]        dropped_count
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_CHECK    = 4'd1;
  localparam logic [3:0] S_ERR_TX   = 4'd2;
  localparam logic [3:0] S_WRITE    = 4'd3;
  localparam logic [3:0] S_ACK_TX   = 4'd4;
  localparam logic [3:0] S_RD_ISSUE = 4'd5;
  localparam logic [3:0] S_RD_WAIT  = 4'd6;
  localparam logic [3:0] S_RD_TX    = 4'd7;
  localparam logic [3:0] S_TX_WAIT  = 4'd8;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  logic [3:0]         state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [7:0]         op_q, op_d;
  logic [1:0]         err_q, err_d;
  logic [BURST_W-1:0] rem_q, rem_d;
  logic               last_q, last_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [DATA_W-1:0]  word_q, word_d;
  logic [7:0]         byte_q, byte_d;
  logic               mode_q, mode_d;
  logic [7:0]         drop_q, drop_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    op_d    = op_q;
    err_d   = err_q;
    rem_d   = rem_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    byte_d  = byte_q;
    mode_d  = mode_q;
    drop_d  = drop_q;
    // commands arriving while busy are discarded and counted
    if (cmd_valid && state_q != S_IDLE && drop_q != 8'hFF)
      drop_d = drop_q + 8'd1;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_address;
          data_d  = cmd_data;
          op_d    = cmd_opcode;
          err_d   = cmd_error;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (err_q != 2'd0) begin
          byte_d  = {6'b0, err_q};
          mode_d  = 1'b0;
          state_d = S_ERR_TX;
        end else if (op_q == 8'h00) begin
          state_d = S_WRITE;
        end else if (op_q == 8'h01) begin
          rem_d   = '0;
          state_d = S_RD_ISSUE;
        end else if (op_q == 8'h02) begin
          rem_d   = data_q[BURST_W-1:0];
          state_d = S_RD_ISSUE;
        end else begin
          byte_d  = 8'h04;
          mode_d  = 1'b0;
          state_d = S_ERR_TX;
        end
      end
      S_ERR_TX, S_ACK_TX: begin
        last_d  = 1'b1;
        state_d = S_TX_WAIT;
      end
      S_WRITE: begin
        if (ACK_WRITES) begin
          byte_d  = 8'h00;
          mode_d  = 1'b0;
          state_d = S_ACK_TX;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD_ISSUE: begin
        cnt_d   = LAT_M1;
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (cnt_q == 4'd0) begin
          word_d  = mem_data_out;
          mode_d  = 1'b1;
          state_d = S_RD_TX;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RD_TX: begin
        last_d  = (rem_q == '0);
        state_d = S_TX_WAIT;
      end
      S_TX_WAIT: begin
        if (tx_done) begin
          if (last_q) begin
            state_d = S_IDLE;
          end else begin
            rem_d   = rem_q - BURST_W'(1);
            addr_d  = addr_q + ADDR_W'(1);
            state_d = S_RD_ISSUE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      op_q    <= '0;
      err_q   <= '0;
      rem_q   <= '0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
      word_q  <= '0;
      byte_q  <= '0;
      mode_q  <= 1'b1;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      op_q    <= op_d;
      err_q   <= err_d;
      rem_q   <= rem_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      byte_q  <= byte_d;
      mode_q  <= mode_d;
      drop_q  <= drop_d;
    end
  end

  assign cmd_ready      = (state_q == S_IDLE);
  assign busy           = ~cmd_ready;
  assign mem_enable     = (state_q == S_WRITE) || (state_q == S_RD_ISSUE);
  assign mem_read_write = (state_q == S_WRITE);
  assign mem_address    = mem_enable ? addr_q : '0;
  assign mem_data_in    = mem_read_write ? data_q : '0;
  assign tx_enable      = (state_q == S_ERR_TX) || (state_q == S_ACK_TX)
                       || (state_q == S_RD_TX);
  assign tx_mode_select = mode_q;
  assign tx_word        = word_q;
  assign tx_byte        = byte_q;
  assign dropped_count  = drop_q;

endmodule

// File: tb/tb_cmd_executor.sv
// Bench for cmd_executor: transaction-level scoreboard model plus
// directed scenarios and a reduced-parameter second instance.
module tb_cmd_executor;

  localparam int LAT = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [7:0]  cmd_opcode = '0;
  logic [14:0] cmd_address = '0;
  logic [31:0] cmd_data = '0;
  logic [1:0]  cmd_error = '0;
  logic        cmd_ready, mem_enable, mem_read_write;
  logic [14:0] mem_address;
  logic [31:0] mem_data_in, mem_data_out;
  logic        tx_enable, tx_mode_select;
  logic [31:0] tx_word;
  logic [7:0]  tx_byte;
  logic        tx_done = 1'b0;
  logic        busy;
  logic [7:0]  dropped_count;

  always #5 clock = ~clock;

  cmd_executor #(
    .ADDR_W(15), .DATA_W(32), .MEM_LAT(LAT),
    .BURST_W(4), .ACK_WRITES(1'b1)
  ) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid),
    .cmd_opcode(cmd_opcode), .cmd_address(cmd_address),
    .cmd_data(cmd_data), .cmd_error(cmd_error),
    .cmd_ready(cmd_ready), .mem_enable(mem_enable),
    .mem_read_write(mem_read_write), .mem_address(mem_address),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .tx_enable(tx_enable), .tx_mode_select(tx_mode_select),
    .tx_word(tx_word), .tx_byte(tx_byte), .tx_done(tx_done),
    .busy(busy), .dropped_count(dropped_count)
  );

  // reduced-parameter instance
  logic        v1 = 1'b0;
  logic [7:0]  op1 = '0;
  logic [9:0]  a1 = '0;
  logic [15:0] d1 = '0;
  logic [1:0]  e1 = '0;
  logic        rdy1, me1, rw1, txe1, txm1, busy1, done1 = 1'b0;
  logic [9:0]  ma1;
  logic [15:0] mdi1, mdo1, txw1;
  logic [7:0]  txb1, drop1;

  cmd_executor #(
    .ADDR_W(10), .DATA_W(16), .MEM_LAT(1),
    .BURST_W(4), .ACK_WRITES(1'b0)
  ) dut1 (
    .clock(clock), .reset(reset), .cmd_valid(v1),
    .cmd_opcode(op1), .cmd_address(a1), .cmd_data(d1),
    .cmd_error(e1), .cmd_ready(rdy1), .mem_enable(me1),
    .mem_read_write(rw1), .mem_address(ma1),
    .mem_data_in(mdi1), .mem_data_out(mdo1),
    .tx_enable(txe1), .tx_mode_select(txm1),
    .tx_word(txw1), .tx_byte(txb1), .tx_done(done1),
    .busy(busy1), .dropped_count(drop1)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // SRAM emulation: data valid LAT edges after the issuing edge
  logic [31:0] ram [0:32767];
  logic [31:0] p0, p1;
  always @(posedge clock) begin
    if (mem_enable && mem_read_write) ram[mem_address] <= mem_data_in;
    p0 <= (mem_enable && !mem_read_write) ? ram[mem_address]
                                          : 32'hBADBAD00;
    p1 <= p0;
  end
  assign mem_data_out = p1;

  logic [15:0] ram1 [0:1023];
  logic [15:0] q1;
  always @(posedge clock) begin
    if (me1 && rw1) ram1[ma1] <= mdi1;
    q1 <= (me1 && !rw1) ? ram1[ma1] : 16'hBAD0;
  end
  assign mdo1 = q1;

  // transmitter responder
  int done_delay = 3;
  initial begin
    forever begin
      @(negedge clock);
      if (tx_enable) begin
        repeat (done_delay) @(posedge clock);
        #1 tx_done = 1'b1;
        @(posedge clock);
        #1 tx_done = 1'b0;
      end
    end
  end

  // ---------------- behavioural model ----------------
  typedef struct { int c; bit rw; int a; logic [31:0] d; } mem_ev_t;
  typedef struct { int c; bit mode; logic [31:0] v; } tx_ev_t;

  mem_ev_t mq[$];
  tx_ev_t  tq[$];
  tx_ev_t  tx_log[$];
  bit [31:0] ref_mem [int];

  bit     chk_en = 1'b0;
  bit     clr_next = 1'b0;
  bit     m_busy = 1'b0;
  int     m_free_at = -1;
  int     m_words = 0;
  int     m_addr = 0;
  bit     m_await = 1'b0;
  int     m_drop = 0;
  bit     tx_out = 1'b0;
  int     mem_cnt = 0;
  tx_ev_t last_tx;

  task automatic schedule_read(input int c);
    mq.push_back('{c, 1'b0, m_addr, 32'h0});
    tq.push_back('{c + LAT + 1, 1'b1, ref_mem[m_addr]});
    m_addr = (m_addr + 1) & 32'h7FFF;
    m_words--;
  endtask

  task automatic accept(input logic [7:0] op, input int a,
                        input logic [31:0] d, input logic [1:0] er);
    m_busy = 1'b1;
    if (er != 2'd0) begin
      tq.push_back('{cyc + 2, 1'b0, {30'd0, er}});
    end else if (op == 8'h00) begin
      mq.push_back('{cyc + 2, 1'b1, a, d});
      ref_mem[a] = d;
      tq.push_back('{cyc + 3, 1'b0, 32'h0});
    end else if (op == 8'h01 || op == 8'h02) begin
      m_addr  = a;
      m_words = (op == 8'h02) ? int'(d[3:0]) + 1 : 1;
      schedule_read(cyc + 2);
    end else begin
      tq.push_back('{cyc + 2, 1'b0, 32'h4});
    end
  endtask

  always @(negedge clock) begin
    mem_ev_t me;
    tx_ev_t  te;
    if (chk_en) begin
      if (clr_next) begin
        clr_next = 1'b0;
        m_busy = 1'b0; m_free_at = -1; m_words = 0;
        m_await = 1'b0; m_drop = 0; tx_out = 1'b0;
        mq.delete(); tq.delete();
        chk("rst_ctrl", {mem_enable, mem_read_write, tx_enable,
            tx_mode_select, cmd_ready, busy}, 6'b000110);
        chk("rst_addr_wdata", {mem_address, mem_data_in}, 0);
        chk("rst_tx_data", {tx_word, tx_byte}, 0);
        chk("rst_dropped", dropped_count, 0);
      end
      if (cyc == m_free_at) begin
        m_busy = 1'b0;
        m_free_at = -1;
      end
      chk("cmd_ready", cmd_ready, !m_busy);
      chk("busy", busy, m_busy);
      chk("dropped_count", dropped_count, m_drop);

      if (mem_enable) mem_cnt++;
      if (mem_enable || (mq.size() > 0 && mq[0].c <= cyc)) begin
        if (mq.size() == 0) begin
          chk("mem_spurious", mem_enable, 1'b0);
        end else begin
          me = mq.pop_front();
          chk("mem_enable", mem_enable, 1'b1);
          chk("mem_cycle", cyc, me.c);
          chk("mem_rw", mem_read_write, me.rw);
          chk("mem_addr", mem_address, me.a);
          if (me.rw) chk("mem_wdata", mem_data_in, me.d);
        end
      end

      if (tx_enable || (tq.size() > 0 && tq[0].c <= cyc)) begin
        chk("tx_before_done", tx_out && tx_enable, 1'b0);
        if (tq.size() == 0) begin
          chk("tx_spurious", tx_enable, 1'b0);
        end else begin
          te = tq.pop_front();
          chk("tx_enable", tx_enable, 1'b1);
          chk("tx_cycle", cyc, te.c);
          chk("tx_mode", tx_mode_select, te.mode);
          if (te.mode) chk("tx_word", tx_word, te.v);
          else chk("tx_byte", tx_byte, te.v[7:0]);
          m_await = 1'b1;
          last_tx = te;
        end
        if (tx_enable) begin
          tx_out = 1'b1;
          tx_log.push_back('{cyc, tx_mode_select,
            tx_mode_select ? tx_word : {24'd0, tx_byte}});
        end
      end else if (tx_out) begin
        if (last_tx.mode) chk("tx_hold_word", tx_word, last_tx.v);
        else chk("tx_hold_byte", tx_byte, last_tx.v[7:0]);
      end

      if (reset) begin
        clr_next = 1'b1;
      end else begin
        if (tx_done) begin
          tx_out = 1'b0;
          if (m_await) begin
            m_await = 1'b0;
            if (m_words > 0) schedule_read(cyc + 1);
            else m_free_at = cyc + 1;
          end
        end
        if (cmd_valid) begin
          if (m_busy) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
          else accept(cmd_opcode, int'(cmd_address), cmd_data, cmd_error);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  int tx1_cnt = 0;
  int tx1_cyc = 0;
  logic [15:0] tx1_word = '0;
  always @(negedge clock) begin
    if (txe1) begin
      tx1_cnt++;
      tx1_cyc = cyc;
      tx1_word = txw1;
    end
  end

  int t0;

  task automatic send(input logic [7:0] op, input logic [14:0] a,
                      input logic [31:0] d, input logic [1:0] er);
    @(posedge clock);
    #1;
    cmd_opcode = op; cmd_address = a; cmd_data = d; cmd_error = er;
    cmd_valid = 1'b1;
    t0 = cyc;
    @(posedge clock);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    @(negedge clock);
    while (!(cmd_ready === 1'b1 && !tx_out) && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (n >= budget) chk("idle_timeout", cmd_ready, 1'b1);
  endtask

  task automatic wait_tx(input int target, input int budget);
    int n;
    n = 0;
    while (tx_log.size() < target && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (n >= budget) chk("tx_timeout", tx_log.size(), target);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n0, mc;
    repeat (3) @(posedge clock);
    #1 chk_en = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    repeat (2) @(posedge clock);

    // write then read
    done_delay = 3;
    n0 = tx_log.size();
    send(8'h00, 15'h0010, 32'hDEADBEEF, 2'd0);
    wait_idle(60);
    chk("ack_count", tx_log.size() - n0, 1);
    chk("ack_byte", {tx_log[$].mode, tx_log[$].v}, 33'h0);
    send(8'h01, 15'h0010, 32'h0, 2'd0);
    wait_idle(60);
    chk("rd_word", tx_log[$].v, 32'hDEADBEEF);
    chk("rd_mode", tx_log[$].mode, 1'b1);
    chk("rd_latency", tx_log[$].c - t0, 5);

    // burst with address wrap
    send(8'h00, 15'h7FFE, 32'd1, 2'd0); wait_idle(60);
    send(8'h00, 15'h7FFF, 32'd2, 2'd0); wait_idle(60);
    send(8'h00, 15'h0000, 32'd3, 2'd0); wait_idle(60);
    send(8'h00, 15'h0001, 32'd4, 2'd0); wait_idle(60);
    done_delay = 100;
    n0 = tx_log.size();
    send(8'h02, 15'h7FFE, 32'd3, 2'd0);
    wait_idle(1000);
    chk("burst_count", tx_log.size() - n0, 4);
    for (int i = 0; i < 4; i++) begin
      chk("burst_word", tx_log[n0 + i].v, i + 1);
      if (i > 0)
        chk("burst_gap", tx_log[n0 + i].c - tx_log[n0 + i - 1].c, 104);
    end

    // decoder and opcode errors
    done_delay = 2;
    mc = mem_cnt;
    send(8'h01, 15'h0010, 32'h0, 2'd2);
    wait_idle(60);
    chk("err_byte", {tx_log[$].mode, tx_log[$].v}, 33'h2);
    chk("err_no_mem", mem_cnt - mc, 0);
    send(8'h07, 15'h0000, 32'h0, 2'd0);
    wait_idle(60);
    chk("op_err_byte", {tx_log[$].mode, tx_log[$].v}, 33'h4);

    // drops while busy
    done_delay = 50;
    mc = mem_cnt;
    n0 = tx_log.size();
    send(8'h01, 15'h0010, 32'h0, 2'd0);
    wait_tx(n0 + 1, 60);
    repeat (3) send(8'h01, 15'h0001, 32'h0, 2'd0);
    wait_idle(200);
    chk("drop3", dropped_count, 8'd3);
    chk("drop_no_mem", mem_cnt - mc, 1);
    done_delay = 400;
    send(8'h01, 15'h0010, 32'h0, 2'd0);
    cmd_valid = 1'b1;
    repeat (300) @(posedge clock);
    #1 cmd_valid = 1'b0;
    wait_idle(1000);
    chk("drop_sat", dropped_count, 8'd255);

    // reset mid-burst
    done_delay = 100;
    n0 = tx_log.size();
    send(8'h02, 15'h7FFE, 32'd3, 2'd0);
    wait_tx(n0 + 2, 400);
    repeat (10) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    repeat (200) @(posedge clock);
    #1;
    chk("rst_no_more_tx", tx_log.size() - n0, 2);
    chk("rst_ready", cmd_ready, 1'b1);

    // reduced-parameter instance: silent write, latency 4
    @(posedge clock);
    #1 op1 = 8'h00; a1 = 10'h3FF; d1 = 16'hA5C3; v1 = 1'b1;
    @(posedge clock);
    #1 v1 = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    chk("sw_write_no_tx", tx1_cnt, 0);
    chk("sw_write_ready", rdy1, 1'b1);
    op1 = 8'h01; v1 = 1'b1;
    t0 = cyc;
    @(posedge clock);
    #1 v1 = 1'b0;
    repeat (8) @(posedge clock);
    #1;
    chk("sw_rd_count", tx1_cnt, 1);
    chk("sw_rd_latency", tx1_cyc - t0, 4);
    chk("sw_rd_word", tx1_word, 16'hA5C3);
    chk("sw_busy_wait", rdy1, 1'b0);
    done1 = 1'b1;
    @(posedge clock);
    #1 done1 = 1'b0;
    @(posedge clock);
    #1;
    chk("sw_ready_after_done", rdy1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
